// File: rtl/core_pkg.sv
// Shared widths and constants for the integer pipeline stages.
package core_pkg;
    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 5;
    localparam int NUM_REGS      = 1 << ADDRESS_WIDTH;
    localparam int CTRL_WIDTH    = 8;

    localparam logic [ADDRESS_WIDTH-1:0] REG_ZERO = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// Register-busy vector: one bit per architectural register, set by an issuing producer and
// cleared by its write-back.
module reg_scoreboard
    import core_pkg::*;
#(
    parameter int ADDRESS_WIDTH = core_pkg::ADDRESS_WIDTH,
    parameter int NUM_REGS      = core_pkg::NUM_REGS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [ADDRESS_WIDTH-1:0] set_addr,
    input  logic                     clr_en,
    input  logic [ADDRESS_WIDTH-1:0] clr_addr,
    input  logic [ADDRESS_WIDTH-1:0] query_addr1,
    input  logic [ADDRESS_WIDTH-1:0] query_addr2,
    output logic                     busy1,
    output logic                     busy2
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Set is applied after clear so a newer pending producer wins over an older write-back.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1 = busy_q[query_addr1];
    assign busy2 = busy_q[query_addr2];

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back operand bypass, RAW hazard stall against the
// register scoreboard, and valid/ready handshakes on both sides plus branch flush.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int DATA_WIDTH    = core_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = core_pkg::ADDRESS_WIDTH,
    parameter int NUM_REGS      = core_pkg::NUM_REGS,
    parameter int CTRL_WIDTH    = core_pkg::CTRL_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,

    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [ADDRESS_WIDTH-1:0] id_rs1,
    input  logic [ADDRESS_WIDTH-1:0] id_rs2,
    input  logic [ADDRESS_WIDTH-1:0] id_rd,
    input  logic                     id_reg_wr,
    input  logic [CTRL_WIDTH-1:0]    id_ctrl,

    input  logic [DATA_WIDTH-1:0]    rg_rd_data1,
    input  logic [DATA_WIDTH-1:0]    rg_rd_data2,

    input  logic                     wb_wrt_en,
    input  logic [ADDRESS_WIDTH-1:0] wb_wrt_dest,
    input  logic [DATA_WIDTH-1:0]    wb_wrt_data,

    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic [DATA_WIDTH-1:0]    ex_imm,
    output logic [DATA_WIDTH-1:0]    ex_op1,
    output logic [DATA_WIDTH-1:0]    ex_op2,
    output logic [ADDRESS_WIDTH-1:0] ex_rd,
    output logic                     ex_reg_wr,
    output logic [CTRL_WIDTH-1:0]    ex_ctrl,

    output logic                     stall
);

    logic                  rs1_nz;
    logic                  rs2_nz;
    logic                  wb_hit1;
    logic                  wb_hit2;
    logic                  busy1;
    logic                  busy2;
    logic                  hz;
    logic                  space;
    logic                  accept;
    logic                  sb_set;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;

    assign rs1_nz  = (id_rs1 != REG_ZERO);
    assign rs2_nz  = (id_rs2 != REG_ZERO);
    assign wb_hit1 = wb_wrt_en && (wb_wrt_dest == id_rs1);
    assign wb_hit2 = wb_wrt_en && (wb_wrt_dest == id_rs2);

    always_comb begin
        op1 = rg_rd_data1;
        op2 = rg_rd_data2;
        if (!rs1_nz) begin
            op1 = '0;
        end else if (wb_hit1) begin
            op1 = wb_wrt_data;
        end
        if (!rs2_nz) begin
            op2 = '0;
        end else if (wb_hit2) begin
            op2 = wb_wrt_data;
        end
    end

    // A same-cycle write-back resolves the dependency, since the bypass supplies the value.
    assign hz = id_valid && ((rs1_nz && busy1 && !wb_hit1) || (rs2_nz && busy2 && !wb_hit2));

    assign stall    = hz;
    assign space    = !ex_valid || ex_ready;
    assign id_ready = space && !hz && !flush;
    assign accept   = id_valid && id_ready;

    // A flushed instruction never reaches write-back, so it must not mark its rd busy.
    assign sb_set = ex_valid && ex_ready && ex_reg_wr && (ex_rd != REG_ZERO) && !flush;

    reg_scoreboard #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .NUM_REGS     (NUM_REGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (sb_set),
        .set_addr   (ex_rd),
        .clr_en     (wb_wrt_en),
        .clr_addr   (wb_wrt_dest),
        .query_addr1(id_rs1),
        .query_addr2(id_rs2),
        .busy1      (busy1),
        .busy2      (busy2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_imm    <= '0;
            ex_op1    <= '0;
            ex_op2    <= '0;
            ex_rd     <= '0;
            ex_reg_wr <= 1'b0;
            ex_ctrl   <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid  <= 1'b1;
            ex_pc     <= id_pc;
            ex_imm    <= id_imm;
            ex_op1    <= op1;
            ex_op2    <= op2;
            ex_rd     <= id_rd;
            ex_reg_wr <= id_reg_wr;
            ex_ctrl   <= id_ctrl;
        end else if (space) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage between decode/register-file read and the execute stage of the 32-bit RISC-V core.
- Captures decoded fields and both register operands with write-back bypass.
- Keeps a register-busy scoreboard so dependent instructions stall until the producing instruction writes back.
- Uses valid/ready handshakes upstream and downstream, with a flush input for taken branches.

Parameters:
DATA_WIDTH, 32, width of operands, PC and immediate
ADDRESS_WIDTH, 5, register address width
NUM_REGS, 32, number of architectural registers (2^ADDRESS_WIDTH)
CTRL_WIDTH, 8, width of opaque ALU/branch control bundle

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
flush  in  1  kill the held instruction and refuse the offered one this cycle
id_valid  in  1  decode offers an instruction
id_ready  out  1  stage accepts the offered instruction this cycle
id_pc  in  DATA_WIDTH  instruction PC
id_imm  in  DATA_WIDTH  sign-extended immediate
id_rs1  in  ADDRESS_WIDTH  source register 1
id_rs2  in  ADDRESS_WIDTH  source register 2
id_rd  in  ADDRESS_WIDTH  destination register
id_reg_wr  in  1  instruction writes rd
id_ctrl  in  CTRL_WIDTH  control bundle, passed through
rg_rd_data1  in  DATA_WIDTH  register-file read data for id_rs1
rg_rd_data2  in  DATA_WIDTH  register-file read data for id_rs2
wb_wrt_en  in  1  write-back write strobe (same signal as register-file write enable)
wb_wrt_dest  in  ADDRESS_WIDTH  write-back destination
wb_wrt_data  in  DATA_WIDTH  write-back data
ex_valid  out  1  execute stage holds a valid instruction
ex_ready  in  1  execute consumes the held instruction
ex_pc, ex_imm, ex_op1, ex_op2  out  DATA_WIDTH  registered fields and operands
ex_rd  out  ADDRESS_WIDTH  registered destination
ex_reg_wr  out  1  registered write flag
ex_ctrl  out  CTRL_WIDTH  registered control bundle
stall  out  1  hazard stall indicator, for performance counting

Behaviour:
- Reset (rst=0, asynchronous): all ex_* outputs are 0, ex_valid=0 and the scoreboard is all-clear.
- Operand bypass (combinational, per source):
  - rs==0 gives 0.
  - Otherwise, wb_wrt_en && wb_wrt_dest==rs gives wb_wrt_data.
  - Otherwise the operand is rg_rd_data.
- Hazard: hz = id_valid && ((rs1!=0 && busy[rs1] && !wbhit1) || (rs2!=0 && busy[rs2] && !wbhit2)).
  - wbhit means a write-back to that register in the same cycle.
  - Both sources are always checked (no per-instruction use masks).
- Outputs derived from the hazard:
  - stall = hz.
  - space = !ex_valid || ex_ready.
  - id_ready = space && !hz && !flush.
- Accept (id_valid && id_ready): on the next rising edge all ex_* fields load, ex_valid=1 and the operands take their bypassed values. Latency is 1 cycle.
- Drain without accept (space && !accept): ex_valid becomes 0 (bubble) and the data fields hold their old values.
- Hold (ex_valid && !ex_ready && !flush): all ex_* outputs hold.
- Flush: ex_valid becomes 0 next edge regardless of ex_ready; the offered instruction is not accepted; data fields hold.
- Scoreboard: NUM_REGS-bit busy vector; bit 0 is never set.
  - Set busy[ex_rd] when ex_valid && ex_ready && ex_reg_wr && ex_rd!=0 and no flush. A flushed instruction never sets busy.
  - Clear busy[wb_wrt_dest] when wb_wrt_en.
  - Simultaneous set and clear of the same register: set wins, because the newer producer is pending.
  - Flush does not clear busy bits; older instructions still write back.
- Priority: rst > flush > accept/drain > hold.
- Write-back for a register that is not busy (e.g. a stale path) simply clears nothing new; no error.

Decomposition:
- Shared package core_pkg holds DATA_WIDTH, ADDRESS_WIDTH, NUM_REGS, CTRL_WIDTH and the reg-zero constant.
- One sub-module: reg_scoreboard.
  - Inputs: set strobe and address, clear strobe and address, two query addresses.
  - Outputs: two busy flags.
  - Contains the asynchronous-reset busy vector.
- Bypass muxes and handshake logic stay in id_ex_stage.

Test Plan:
1. Reset and pass-through. Release rst, offer pc=0x10, rs1=1, rs2=2, rg data 0xA/0xB, ex_ready=1.
   -> id_ready=1 and, next cycle, ex_valid=1, ex_op1=0xA, ex_op2=0xB, ex_pc=0x10.
2. WB bypass. Offer rs1=5 with rg_rd_data1=0x1 while wb_wrt_en=1, dest=5, data=0xDEAD.
   -> ex_op1=0xDEAD. With rs1=0 and wb dest=0, ex_op1=0.
3. RAW stall. Instruction A (rd=3, reg_wr) leaves the stage; then offer B with rs2=3.
   -> stall=1 and id_ready=0 until the cycle wb_wrt_en writes dest=3 with data 0x77.
   -> In that cycle B is accepted and ex_op2=0x77.
4. Back-pressure. Hold ex_ready=0 for 3 cycles with id_valid=1.
   -> id_ready=0 and all ex_* outputs are stable. On ex_ready=1, the next instruction loads in 1 cycle.
5. Flush. ex_valid=1 (rd=4, reg_wr) with ex_ready=0; assert flush for 1 cycle.
   -> ex_valid=0 next cycle, busy[4] stays 0, and the offered instruction is not accepted.
6. Async reset mid-operation. busy[7]=1 and ex_valid=1; drive rst=0 between clock edges.
   -> ex_valid=0 and the scoreboard clears immediately, without waiting for a clock edge.
   -> A subsequent instruction with rs1=7 is not stalled.
